// File: rtl/pipeline_if_fetch.sv
// Instruction fetch stage: owns the PC, issues one imem request at a time, and buffers words for ID.
// Define SBP_EN to let the static predictor steer next_pc; otherwise fetch is sequential.
module pipeline_if_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid_o,
   input  logic        imem_req_ready_i,
   output logic [31:0] imem_addr_o,
   input  logic        imem_rsp_valid_i,
   input  logic [31:0] imem_rsp_data_i,
   input  logic        redirection_e_i,
   input  logic [31:0] redirection_pc_e_i,
   input  logic        st_f_i,
   output logic        valid_f_o,
   output logic [31:0] instr_f_o,
   output logic [31:0] pc_f_o,
   output logic [31:0] pc_plus4_f_o,
   output logic        taken_f_o,
   output logic [31:0] prediction_pc_f_o
);
   // state  | meaning
   // S_REQ  | no request outstanding; request pc when the buffer has room
   // S_WAIT | request accepted; next response is pushed into the buffer
   // S_DROP | request accepted before a redirect; next response is discarded
   typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

   localparam int AW = $clog2(FIFO_DEPTH);

   state_t          state_q, state_d;
   logic [31:0]     pc_q, pc_d;
   logic [AW:0]     count_q;
   logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
   logic [31:0]     instr_mem [FIFO_DEPTH];
   logic [31:0]     pc_mem    [FIFO_DEPTH];
   logic [31:0]     pc4_mem   [FIFO_DEPTH];
   logic [31:0]     ppc_mem   [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] taken_mem;

   logic        is_branch, is_jal, pred_taken, accept, push, pop;
   logic [31:0] imm_b, imm_j, pc_plus4, pred_target, next_pc;

   assign is_branch   = (imem_rsp_data_i[6:0] == 7'b1100011);
   assign is_jal      = (imem_rsp_data_i[6:0] == 7'b1101111);
   assign imm_b       = {{19{imem_rsp_data_i[31]}}, imem_rsp_data_i[31], imem_rsp_data_i[7],
                         imem_rsp_data_i[30:25], imem_rsp_data_i[11:8], 1'b0};
   assign imm_j       = {{11{imem_rsp_data_i[31]}}, imem_rsp_data_i[31], imem_rsp_data_i[19:12],
                         imem_rsp_data_i[20], imem_rsp_data_i[30:21], 1'b0};
   assign pc_plus4    = pc_q + 32'd4;
   assign pred_target = is_branch ? pc_q + imm_b :
                        is_jal    ? pc_q + imm_j : pc_plus4;

`ifdef SBP_EN
   assign pred_taken  = (is_branch & imem_rsp_data_i[31]) | is_jal;
   assign next_pc     = pred_taken ? pred_target : pc_plus4;
`else
   // target is still recorded so EXE can resolve the branch and redirect
   assign pred_taken  = 1'b0;
   assign next_pc     = pc_plus4;
`endif

   assign imem_req_valid_o = ~reset & (state_q == S_REQ) & ~redirection_e_i &
                             (count_q < (AW+1)'(FIFO_DEPTH));
   assign imem_addr_o      = pc_q;
   assign accept           = imem_req_valid_o & imem_req_ready_i;
   assign push             = (state_q == S_WAIT) & imem_rsp_valid_i & ~redirection_e_i;
   assign pop              = valid_f_o & ~st_f_i & ~redirection_e_i;

   assign valid_f_o         = (count_q != '0);
   assign instr_f_o         = instr_mem[rd_ptr_q];
   assign pc_f_o            = pc_mem[rd_ptr_q];
   assign pc_plus4_f_o      = pc4_mem[rd_ptr_q];
   assign prediction_pc_f_o = ppc_mem[rd_ptr_q];
   assign taken_f_o         = taken_mem[rd_ptr_q];

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      if (redirection_e_i) begin
         pc_d = redirection_pc_e_i & ~32'h3;
         if (state_q != S_REQ) state_d = imem_rsp_valid_i ? S_REQ : S_DROP;
      end else begin
         case (state_q)
            S_REQ:   if (accept) state_d = S_WAIT;
            S_WAIT:  if (imem_rsp_valid_i) begin
                        state_d = S_REQ;
                        pc_d    = next_pc;
                     end
            S_DROP:  if (imem_rsp_valid_i) state_d = S_REQ;
            default: state_d = S_REQ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_REQ;
         pc_q      <= RESET_PC;
         count_q   <= '0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         taken_mem <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            instr_mem[i] <= '0;
            pc_mem[i]    <= '0;
            pc4_mem[i]   <= '0;
            ppc_mem[i]   <= '0;
         end
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         if (redirection_e_i) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
         end else begin
            if (push) begin
               instr_mem[wr_ptr_q] <= imem_rsp_data_i;
               pc_mem[wr_ptr_q]    <= pc_q;
               pc4_mem[wr_ptr_q]   <= pc_plus4;
               ppc_mem[wr_ptr_q]   <= pred_target;
               taken_mem[wr_ptr_q] <= pred_taken;
               wr_ptr_q            <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
               2'b10:   count_q <= count_q + 1'b1;
               2'b01:   count_q <= count_q - 1'b1;
               default: count_q <= count_q;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_pipeline_if_fetch.sv
// Bench for pipeline_if_fetch: imem model plus a queue-based reference of the fetch stream.
module tb_pipeline_if_fetch;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req_valid_o, imem_req_ready_i = 1'b1;
   logic [31:0] imem_addr_o;
   logic        imem_rsp_valid_i = 1'b0;
   logic [31:0] imem_rsp_data_i = '0;
   logic        redirection_e_i = 1'b0;
   logic [31:0] redirection_pc_e_i = '0;
   logic        st_f_i = 1'b0;
   logic        valid_f_o, taken_f_o;
   logic [31:0] instr_f_o, pc_f_o, pc_plus4_f_o, prediction_pc_f_o;

   pipeline_if_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
      .imem_addr_o(imem_addr_o), .imem_rsp_valid_i(imem_rsp_valid_i),
      .imem_rsp_data_i(imem_rsp_data_i), .redirection_e_i(redirection_e_i),
      .redirection_pc_e_i(redirection_pc_e_i), .st_f_i(st_f_i),
      .valid_f_o(valid_f_o), .instr_f_o(instr_f_o), .pc_f_o(pc_f_o),
      .pc_plus4_f_o(pc_plus4_f_o), .taken_f_o(taken_f_o),
      .prediction_pc_f_o(prediction_pc_f_o));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc, instr, pc4, ppc;
      logic        taken;
   } ent_t;

   int n_chk = 0, n_pass = 0;
   bit chk_en = 0;

   // reference model state
   logic [31:0] m_pc = RESET_PC;
   bit          m_out = 0, m_stale = 0;
   ent_t        m_q[$];

   // memory model state and logs of what the DUT did
   logic [31:0] mem [logic [31:0]];
   bit          mem_pend = 0;
   int          mem_cnt = 0, lat = 1;
   logic [31:0] mem_addr = '0;
   logic [31:0] acc_log[$];
   ent_t        pop_log[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [31:0] rd_mem(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return 32'h0000_0013;
   endfunction

   function automatic ent_t mk(input logic [31:0] pc, input logic [31:0] w);
      ent_t e;
      logic [12:0] ib;
      logic [20:0] ij;
      int imm;
      e.pc = pc; e.instr = w; e.pc4 = pc + 32'd4; e.ppc = pc + 32'd4; e.taken = 1'b0;
      if (w[6:0] == 7'b1100011) begin
         ib = {w[31], w[7], w[30:25], w[11:8], 1'b0};
         imm = $signed(ib);
         e.ppc = pc + 32'(imm);
`ifdef SBP_EN
         e.taken = (imm < 0);
`endif
      end else if (w[6:0] == 7'b1101111) begin
         ij = {w[31], w[19:12], w[20], w[30:21], 1'b0};
         imm = $signed(ij);
         e.ppc = pc + 32'(imm);
`ifdef SBP_EN
         e.taken = 1'b1;
`endif
      end
      return e;
   endfunction

   task automatic check_outputs();
      bit exp_req;
      exp_req = !reset && !m_out && (m_q.size() < DEPTH) && !redirection_e_i;
      chk("req_valid", {31'b0, imem_req_valid_o}, {31'b0, exp_req});
      if (exp_req) chk("req_addr", imem_addr_o, m_pc);
      chk("valid_f", {31'b0, valid_f_o}, {31'b0, m_q.size() != 0});
      if (m_q.size() != 0) begin
         chk("instr_f", instr_f_o, m_q[0].instr);
         chk("pc_f", pc_f_o, m_q[0].pc);
         chk("pc_plus4_f", pc_plus4_f_o, m_q[0].pc4);
         chk("taken_f", {31'b0, taken_f_o}, {31'b0, m_q[0].taken});
         chk("pred_pc_f", prediction_pc_f_o, m_q[0].ppc);
      end
   endtask

   task automatic model_update();
      ent_t e;
      bit   req_go;
      if (reset) begin
         m_pc = RESET_PC; m_out = 0; m_stale = 0; m_q.delete();
      end else if (redirection_e_i) begin
         m_pc = redirection_pc_e_i & ~32'h3;
         m_q.delete();
         if (m_out) begin
            if (imem_rsp_valid_i) begin m_out = 0; m_stale = 0; end
            else m_stale = 1;
         end
      end else begin
         req_go = !m_out && (m_q.size() < DEPTH) && imem_req_ready_i;
         if (m_q.size() != 0 && !st_f_i) void'(m_q.pop_front());
         if (m_out) begin
            if (imem_rsp_valid_i) begin
               if (!m_stale) begin
                  e = mk(m_pc, imem_rsp_data_i);
                  m_q.push_back(e);
                  m_pc = e.taken ? e.ppc : e.pc4;
               end
               m_out = 0; m_stale = 0;
            end
         end else if (req_go) m_out = 1;
      end
   endtask

   task automatic step();
      ent_t e;
      @(negedge clk);
      if (chk_en) check_outputs();
      if (!reset && valid_f_o && !st_f_i && !redirection_e_i) begin
         e.pc = pc_f_o; e.instr = instr_f_o; e.pc4 = pc_plus4_f_o;
         e.ppc = prediction_pc_f_o; e.taken = taken_f_o;
         pop_log.push_back(e);
      end
      if (!reset && imem_req_valid_o && imem_req_ready_i) begin
         acc_log.push_back(imem_addr_o);
         mem_pend = 1; mem_cnt = lat; mem_addr = imem_addr_o;
      end
      model_update();
      @(posedge clk); #1;
      imem_rsp_valid_i = 1'b0;
      if (mem_pend) begin
         if (mem_cnt <= 1) begin
            imem_rsp_valid_i = 1'b1;
            imem_rsp_data_i  = rd_mem(mem_addr);
            mem_pend = 0;
         end else mem_cnt--;
      end
      imem_req_ready_i = !mem_pend;
   endtask

   task automatic wait_accept(input string name);
      int n;
      n = acc_log.size();
      for (int i = 0; i < 20 && acc_log.size() == n; i++) step();
      if (acc_log.size() == n) chk({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic wait_pop(input string name);
      int n;
      n = pop_log.size();
      for (int i = 0; i < 30 && pop_log.size() == n; i++) step();
      if (pop_log.size() == n) chk({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int    n0;
      bit    found;
      logic [31:0] nxt;
      ent_t  bq;
      mem[32'h10] = 32'hFE00_0EE3;

      // reset state
      step();
      chk_en = 1;
      step(); step();
      chk("rst_valid_f", {31'b0, valid_f_o}, 32'd0);
      chk("rst_req_valid", {31'b0, imem_req_valid_o}, 32'd0);
      chk("rst_instr", instr_f_o, 32'd0);
      chk("rst_pc", pc_f_o, 32'd0);
      chk("rst_pc4", pc_plus4_f_o, 32'd0);
      chk("rst_ppc", prediction_pc_f_o, 32'd0);
      chk("rst_taken", {31'b0, taken_f_o}, 32'd0);

      // sequential fetch and the backward beq at 0x10
      reset = 1'b0;
      for (int i = 0; i < 18; i++) step();
      chk("seq_req0", acc_log[0], 32'h0);
      chk("seq_req1", acc_log[1], 32'h4);
      chk("seq_req2", acc_log[2], 32'h8);
      chk("seq_pop0_pc", pop_log[0].pc, 32'h0);
      chk("seq_pop0_pc4", pop_log[0].pc4, 32'h4);
      chk("seq_pop1_pc", pop_log[1].pc, 32'h4);
      found = 0; nxt = '0;
      for (int i = 0; i + 1 < acc_log.size(); i++)
         if (!found && acc_log[i] == 32'h10) begin found = 1; nxt = acc_log[i+1]; end
      chk("beq_fetched", {31'b0, found}, 32'd1);
`ifdef SBP_EN
      chk("beq_next_req", nxt, 32'hC);
`else
      chk("beq_next_req", nxt, 32'h14);
`endif
      found = 0; bq = '0;
      for (int i = 0; i < pop_log.size(); i++)
         if (!found && pop_log[i].pc == 32'h10) begin found = 1; bq = pop_log[i]; end
      chk("beq_popped", {31'b0, found}, 32'd1);
      chk("beq_instr", bq.instr, 32'hFE00_0EE3);
      chk("beq_ppc", bq.ppc, 32'hC);
`ifdef SBP_EN
      chk("beq_taken", {31'b0, bq.taken}, 32'd1);
`else
      chk("beq_taken", {31'b0, bq.taken}, 32'd0);
`endif

      // stall with a full buffer
      st_f_i = 1'b1;
      for (int i = 0; i < 6; i++) step();
      chk("stall_valid_f", {31'b0, valid_f_o}, 32'd1);
      chk("stall_no_req", {31'b0, imem_req_valid_o}, 32'd0);
      st_f_i = 1'b0;
      n0 = pop_log.size();
      step(); step();
      chk("stall_drain_back2back", pop_log.size() - n0, 32'd2);

      // redirect while the request to 0x20 is outstanding
      lat = 3;
      redirection_e_i = 1'b1; redirection_pc_e_i = 32'h20;
      step();
      redirection_e_i = 1'b0;
      wait_accept("acc20");
      chk("acc20_addr", acc_log[$], 32'h20);
      lat = 1;
      redirection_e_i = 1'b1; redirection_pc_e_i = 32'h103;
      step();
      redirection_e_i = 1'b0;
      #1;
      chk("redir_flush", {31'b0, valid_f_o}, 32'd0);
      wait_accept("acc100");
      chk("redir_req_addr", acc_log[$], 32'h100);
      wait_pop("pop100");
      chk("redir_first_pc", pop_log[$].pc, 32'h100);

      // redirect in the same cycle as the response
      wait_accept("acc_same");
      redirection_e_i = 1'b1; redirection_pc_e_i = 32'h200;
      chk("same_rsp_present", {31'b0, imem_rsp_valid_i}, 32'd1);
      step();
      redirection_e_i = 1'b0;
      #1;
      chk("same_req_valid", {31'b0, imem_req_valid_o}, 32'd1);
      chk("same_req_addr", imem_addr_o, 32'h200);
      for (int i = 0; i < 4; i++) step();

      // reset while waiting, late response lands after reset
      lat = 4;
      wait_accept("acc_late");
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      lat = 1;
      n0 = pop_log.size();
      wait_pop("pop_after_reset");
      chk("reset_first_pc", pop_log[n0].pc, RESET_PC);
      for (int i = 0; i < 4; i++) step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/pipeline_if_fetch.md
Name: pipeline_if_fetch

Overview:
- IF stage of the 5-stage pipeline, sitting in front of ID.
- Owns the PC and issues instruction-memory requests through a valid/ready request channel with a separate response channel.
- Buffers fetched words in a small FIFO and presents them to ID together with the static-prediction fields that EXE later checks.
- Consumes the EXE redirect interface (redirection, redirection_pc) and recovers from mispredictions by flushing and discarding stale responses.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset
FIFO_DEPTH, 2, instruction buffer entries (power of two, >=2)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
imem_req_valid_o  out  1  fetch request valid
imem_req_ready_i  in  1  memory accepts request
imem_addr_o  out  32  fetch address, word aligned
imem_rsp_valid_i  in  1  response valid, one per accepted request
imem_rsp_data_i  in  32  instruction word
redirection_e_i  in  1  EXE redirect
redirection_pc_e_i  in  32  redirect target
st_f_i  in  1  hazard stall: ID not consuming this cycle
valid_f_o  out  1  FIFO head valid to ID
instr_f_o  out  32  head instruction
pc_f_o  out  32  head PC
pc_plus4_f_o  out  32  head PC+4
taken_f_o  out  1  static prediction taken
prediction_pc_f_o  out  32  branch/jump target (pc+imm) for B-type/JAL, else pc+4

Behaviour:
- Reset: state REQ, pc=RESET_PC, FIFO empty, outstanding=0; outputs valid_f_o=0, imem_req_valid_o=0, instr/pc/pc_plus4/prediction_pc=0, taken_f_o=0. First request appears the cycle after reset deasserts. Reset mid-fetch abandons the outstanding response; any response arriving in REQ with outstanding=0 is ignored.
- FSM:
  - REQ: imem_req_valid_o=1 with imem_addr_o=pc when fifo_count+outstanding<FIFO_DEPTH; otherwise 0. valid&ready -> WAIT, outstanding=1.
  - WAIT: on imem_rsp_valid_i, push {data, pc, predict fields} into the FIFO, pc<=next_pc, -> REQ.
  - DROP: on imem_rsp_valid_i, discard the response, -> REQ.
- At most one outstanding request. Response latency >=1 cycle after acceptance. imem_addr_o is held stable while valid&~ready, except on redirect.
- next_pc: predicted target if taken, else pc+4. 32-bit wrap-around; 32'hFFFF_FFFC+4 = 0.
- Static predictor (SBP_EN):
  - B-type (opcode 1100011): taken when imm sign=1 (backward).
  - JAL (1101111): always taken.
  - target = pc + sign-extended imm, truncated to 32 bits.
  - JALR: not taken; prediction_pc = pc+4.
- Consume: head is popped when valid_f_o & ~st_f_i. Push and pop in the same cycle are both honoured, including when the FIFO is full. Output fields are the FIFO head, registered.
- Redirect (highest priority, over stall and response):
  - pc<=redirection_pc_e_i & ~32'h3.
  - FIFO flushed; valid_f_o=0 next cycle.
  - From REQ: the pending request is retracted; a request to the new pc is issued the following cycle.
  - From WAIT: -> DROP, or -> REQ if the response arrives that same cycle (that response is discarded).
  - From DROP: stays in DROP, target updated.
- Stall with a full FIFO: no new request. An in-flight response is never lost: issue is gated on fifo_count+outstanding < FIFO_DEPTH.

Optional Feature:
SBP_EN
- Defined: prediction as above.
- Undefined: taken_f_o=0 always and next_pc=pc+4. prediction_pc_f_o still carries pc+imm for B-type/JAL so EXE can redirect. Predictor mux logic is removed.

Test Plan:
- Reset, ready=1, rsp latency 1, words NOP (32'h00000013) -> requests at 0x0, 0x4, 0x8; valid_f_o with pc_f_o=0x0 then 0x4; pc_plus4_f_o=0x4.
- Word 32'hFE000EE3 (beq x0,x0,-4) at 0x10 -> taken_f_o=1, prediction_pc_f_o=0xC, next request to 0xC; with SBP_EN undefined: taken_f_o=0, next request 0x14, prediction_pc_f_o=0xC.
- st_f_i held 6 cycles, FIFO_DEPTH=2 -> two entries buffered, imem_req_valid_o=0 afterwards, no response dropped; release -> pcs emerge in order with no gap.
- Request 0x20 accepted, redirection_e_i=1 to 0x103 before the response -> response for 0x20 discarded, next request to 0x100, FIFO empty next cycle.
- Redirect to 0x200 in the same cycle imem_rsp_valid_i=1 -> response discarded, FSM to REQ, request 0x200 next cycle.
- Reset asserted in WAIT, late response arrives in REQ -> ignored, first valid_f_o carries pc=RESET_PC.
